// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter for the single register file write port,
// with registered write outputs and a pending-write scoreboard.
module regfile_write_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stall,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            reserve_valid,
  input  logic [ADDR_WIDTH-1:0]           reserve_addr,
  output logic [2**ADDR_WIDTH-1:0]        busy_mask,
  output logic                            rf_regWrite,
  output logic [ADDR_WIDTH-1:0]           rf_writeRegister,
  output logic [DATA_WIDTH-1:0]           rf_writeData,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int NREG = 2**ADDR_WIDTH;
  localparam logic [IDW:0]   NR   = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ-1);

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic [NUM_REQ-1:0]    rot;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDW-1:0]        off;
  logic [IDW:0]          sum;
  logic [IDW-1:0]        gidx;
  logic                  found;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  // Rotate valids so bit 0 is the requester at the pointer.
  assign rot = (req_valid >> ptr_q)
             | (req_valid << (NUM_REQ - int'(ptr_q)));

  // Pick the first valid after the pointer; the stall and reset gate it.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NR) sum = sum - NR;
    gidx = sum[IDW-1:0];
    if (stall || !rst_n) found = 1'b0;
  end

  // One-hot grant plus the selected address and data.
  always_comb begin
    gnt      = '0;
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = found && (gidx == IDW'(i));
      if (gnt[i]) begin
        addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = gnt;

  // Next state: pointer, write port, scoreboard (set beats clear).
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    gid_d  = gid_q;
    busy_d = busy_q;
    if (found) begin
      ptr_d  = (gidx == LAST) ? '0 : gidx + IDW'(1);
      we_d   = (addr_sel != '0);
      wa_d   = addr_sel;
      wd_d   = data_sel;
      gid_d  = gidx;
      busy_d[addr_sel] = 1'b0;
    end
    if (reserve_valid && reserve_addr != '0)
      busy_d[reserve_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      gid_q  <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      gid_q  <= gid_d;
      busy_q <= busy_d;
    end
  end

  assign rf_regWrite      = we_q;
  assign rf_writeRegister = wa_q;
  assign rf_writeData     = wd_q;
  assign grant_id         = gid_q;
  assign busy_mask        = busy_q;

endmodule
